ula: RTL and testbench

Combinational arithmetic/logic unit of the REDUX-V datapath, with a small registered flag file. Takes two `BITS`-wide operands and an operation code from the control unit. Drives the result combinationally in the same cycle. Optionally captures zero/negative/carry/overflow flags on the clock edge for branch evaluation.

---
 rtl/ula_pkg.sv | 29 ++
 rtl/ula_adder.sv | 31 +++
 rtl/ula.sv | 111 +++++++++++
 tb/tb_ula.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ula_pkg : opcode map and flag bit positions for the REDUX-V ALU           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package ula_pkg;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_AND   = 1;
  localparam int unsigned OP_OR    = 2;
  localparam int unsigned OP_XOR   = 3;
  localparam int unsigned OP_NOT   = 4;
  localparam int unsigned OP_SUB   = 5;
  localparam int unsigned OP_SLL   = 6;
  localparam int unsigned OP_SRL   = 7;
  localparam int unsigned OP_SRA   = 8;
  localparam int unsigned OP_PASSA = 9;
  localparam int unsigned OP_PASSB = 10;
  localparam int unsigned OP_SLT   = 11;
  localparam int unsigned OP_SLTU  = 12;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_W = 4;

endpackage : ula_pkg
`default_nettype wire

// File: rtl/ula_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ula_adder : BITS-wide adder with carry-in and optional B inversion        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ula_adder #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] a_in,
  input  logic [BITS-1:0] b_in,
  input  logic            inv_b_in,
  input  logic            carry_in,
  output logic [BITS-1:0] sum_out,
  output logic            carry_out,
  output logic            overflow_out
);

  logic [BITS-1:0] b_eff;
  logic [BITS:0]   full_sum;

  assign b_eff    = inv_b_in ? ~b_in : b_in;
  assign full_sum = {1'b0, a_in} + {1'b0, b_eff} + {{BITS{1'b0}}, carry_in};

  assign sum_out   = full_sum[BITS-1:0];
  assign carry_out = full_sum[BITS];
  // Overflow judged on the effective (possibly inverted) B, so it covers SUB too.
  assign overflow_out = (a_in[BITS-1] == b_eff[BITS-1]) &&
                        (full_sum[BITS-1] != a_in[BITS-1]);

endmodule : ula_adder
`default_nettype wire

// File: rtl/ula.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ula : combinational ALU with a registered {V,C,N,Z} flag file             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ula
  import ula_pkg::*;
#(
  parameter int ULA_OP = 4,
  parameter int BITS   = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [BITS-1:0]   a_in,
  input  logic [BITS-1:0]   b_in,
  input  logic [ULA_OP-1:0] ula_op_in,
  input  logic              flag_en_in,
  output logic [BITS-1:0]   result_out,
  output logic [3:0]        flags_out
);

  localparam int SH_W = $clog2(BITS);

  logic [31:0]       op_val;
  logic [BITS-1:0]   sum;
  logic              carry;
  logic              ovf;
  logic              use_sub;
  logic [SH_W-1:0]   shamt;
  logic [BITS-1:0]   result;
  logic              is_arith;
  logic [FLAG_W-1:0] flags_next;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] flags_q;

  assign op_val  = 32'(ula_op_in);
  assign use_sub = (op_val != OP_ADD);
  assign shamt   = b_in[SH_W-1:0];

  // One adder serves ADD directly and SUB/SLT/SLTU as a + ~b + 1.
  ula_adder #(
    .BITS (BITS)
  ) u_adder (
    .a_in         (a_in),
    .b_in         (b_in),
    .inv_b_in     (use_sub),
    .carry_in     (use_sub),
    .sum_out      (sum),
    .carry_out    (carry),
    .overflow_out (ovf)
  );

  logic [BITS-1:0] sll_stg [0:SH_W];
  logic [BITS-1:0] srl_stg [0:SH_W];
  logic [BITS-1:0] sra_stg [0:SH_W];

  assign sll_stg[0] = a_in;
  assign srl_stg[0] = a_in;
  assign sra_stg[0] = a_in;

  for (genvar i = 0; i < SH_W; i++) begin : g_shift_stage
    assign sll_stg[i+1] = shamt[i] ? (sll_stg[i] << (2**i)) : sll_stg[i];
    assign srl_stg[i+1] = shamt[i] ? (srl_stg[i] >> (2**i)) : srl_stg[i];
    assign sra_stg[i+1] = shamt[i] ? $unsigned($signed(sra_stg[i]) >>> (2**i))
                                   : sra_stg[i];
  end

  always_comb begin
    result = '0;
    case (op_val)
      OP_ADD:   result = sum;
      OP_AND:   result = a_in & b_in;
      OP_OR:    result = a_in | b_in;
      OP_XOR:   result = a_in ^ b_in;
      OP_NOT:   result = ~a_in;
      OP_SUB:   result = sum;
      OP_SLL:   result = sll_stg[SH_W];
      OP_SRL:   result = srl_stg[SH_W];
      OP_SRA:   result = sra_stg[SH_W];
      OP_PASSA: result = a_in;
      OP_PASSB: result = b_in;
      OP_SLT:   result = {{(BITS-1){1'b0}}, sum[BITS-1] ^ ovf};
      OP_SLTU:  result = {{(BITS-1){1'b0}}, ~carry};
      default:  result = '0;
    endcase
  end

  assign result_out = result;
  assign is_arith   = (op_val == OP_ADD) || (op_val == OP_SUB);

  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_Z] = ~|result;
    flags_next[FLAG_N] = result[BITS-1];
    flags_next[FLAG_C] = is_arith & carry;
    flags_next[FLAG_V] = is_arith & ovf;
    flags_d            = flag_en_in ? flags_next : flags_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_out = flags_q;

endmodule : ula
`default_nettype wire

// File: tb/tb_ula.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ula : directed self-checking bench for the ula ALU                     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ula;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] op;
  logic       flag_en;
  logic [7:0] result;
  logic [3:0] flags;

  int tests_run = 0;
  int tests_failed = 0;

  ula #(
    .ULA_OP (4),
    .BITS   (8)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .a_in       (a),
    .b_in       (b),
    .ula_op_in  (op),
    .flag_en_in (flag_en),
    .result_out (result),
    .flags_out  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic apply(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                       input logic en);
    @(negedge clk);
    op = o; a = av; b = bv; flag_en = en;
    #1;
  endtask

  initial begin
    logic [7:0] ea;
    rst = 1'b1; a = 8'h00; b = 8'h00; op = 4'd0; flag_en = 1'b1;
    #1;
    check("reset_flags_t0", {4'h0, flags}, 8'h00);
    repeat (2) @(negedge clk);
    check("reset_flags_held", {4'h0, flags}, 8'h00);
    rst = 1'b0;

    // Exhaustive combinational sweep; flags are frozen meanwhile.
    flag_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        a = 8'(i); b = 8'(j);
        op = 4'd0;  #1; ea = 8'(i + j);             check("ex_add",  result, ea);
        op = 4'd1;  #1; ea = a & b;                 check("ex_and",  result, ea);
        op = 4'd2;  #1; ea = a | b;                 check("ex_or",   result, ea);
        op = 4'd3;  #1; ea = a ^ b;                 check("ex_xor",  result, ea);
        op = 4'd5;  #1; ea = 8'(i - j);             check("ex_sub",  result, ea);
        op = 4'd11; #1; ea = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
        check("ex_slt", result, ea);
        op = 4'd12; #1; ea = (i < j) ? 8'd1 : 8'd0; check("ex_sltu", result, ea);
      end
    end
    check("sweep_flags_unchanged", {4'h0, flags}, 8'h00);

    apply(4'd1, 8'h3C, 8'h0F, 1'b0);
    check("and_example", result, 8'h0C);

    // flags = {V,C,N,Z}
    apply(4'd0, 8'hFF, 8'h01, 1'b1);
    check("add_wrap_result", result, 8'h00);
    @(negedge clk);
    check("add_wrap_flags", {4'h0, flags}, 8'h05);

    apply(4'd0, 8'h7F, 8'h01, 1'b1);
    check("add_ovf_result", result, 8'h80);
    @(negedge clk);
    check("add_ovf_flags", {4'h0, flags}, 8'h0A);

    apply(4'd5, 8'h80, 8'h01, 1'b1);
    check("sub_ovf_result", result, 8'h7F);
    @(negedge clk);
    check("sub_ovf_flags", {4'h0, flags}, 8'h0C);

    apply(4'd5, 8'h00, 8'h01, 1'b1);
    check("sub_borrow_result", result, 8'hFF);
    @(negedge clk);
    check("sub_borrow_flags", {4'h0, flags}, 8'h02);

    apply(4'd5, 8'h05, 8'h05, 1'b1);
    check("sub_equal_result", result, 8'h00);
    @(negedge clk);
    check("sub_equal_flags", {4'h0, flags}, 8'h05);

    apply(4'd6, 8'h81, 8'h09, 1'b0);
    check("sll_b9", result, 8'h02);
    apply(4'd7, 8'h81, 8'h09, 1'b0);
    check("srl_b9", result, 8'h40);
    apply(4'd8, 8'h81, 8'h09, 1'b0);
    check("sra_b9", result, 8'hC0);
    apply(4'd8, 8'h90, 8'h07, 1'b0);
    check("sra_7", result, 8'hFF);
    apply(4'd7, 8'h90, 8'h04, 1'b0);
    check("srl_4", result, 8'h09);
    apply(4'd6, 8'h03, 8'h06, 1'b0);
    check("sll_6", result, 8'hC0);

    apply(4'd4, 8'h0F, 8'hAA, 1'b1);
    check("not_result", result, 8'hF0);
    @(negedge clk);
    check("not_flags", {4'h0, flags}, 8'h02);

    apply(4'd9, 8'h5A, 8'hA5, 1'b0);
    check("passa", result, 8'h5A);
    apply(4'd10, 8'h5A, 8'hA5, 1'b0);
    check("passb", result, 8'hA5);

    apply(4'd11, 8'hFF, 8'h01, 1'b1);
    check("slt_neg", result, 8'h01);
    @(negedge clk);
    check("slt_flags", {4'h0, flags}, 8'h00);
    apply(4'd12, 8'hFF, 8'h01, 1'b0);
    check("sltu", result, 8'h00);

    apply(4'd15, 8'hFF, 8'hFF, 1'b1);
    check("undef_result", result, 8'h00);
    @(negedge clk);
    check("undef_flags", {4'h0, flags}, 8'h01);

    // Load distinctive flags, then confirm they hold with enable low.
    apply(4'd5, 8'h80, 8'h01, 1'b1);
    @(negedge clk);
    check("hold_setup", {4'h0, flags}, 8'h0C);
    apply(4'd0, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    check("hold_add", {4'h0, flags}, 8'h0C);
    apply(4'd15, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check("hold_undef", {4'h0, flags}, 8'h0C);

    // Reset between edges clears flags at once; result keeps tracking.
    apply(4'd2, 8'h30, 8'h05, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_flags", {4'h0, flags}, 8'h00);
    check("rst_result_or", result, 8'h35);
    op = 4'd0; a = 8'h10; b = 8'h22;
    #1;
    check("rst_result_add", result, 8'h32);
    flag_en = 1'b1;
    op = 4'd5; a = 8'h00; b = 8'h01;
    @(negedge clk);
    check("rst_held_flags", {4'h0, flags}, 8'h00);
    rst = 1'b0;
    #1;
    check("rst_released_flags", {4'h0, flags}, 8'h00);
    @(negedge clk);
    check("post_rst_update", {4'h0, flags}, 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ula
`default_nettype wire
